// File: rtl/alu_arbiter.sv
// Two-requester sequencer for one shared combinational ALU: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default build is round-robin.
module alu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               r0_req_valid,
    output logic               r0_req_ready,
    input  logic [OP_W-1:0]    r0_op,
    input  logic [DATA_W-1:0]  r0_a,
    input  logic [DATA_W-1:0]  r0_b,
    input  logic [SHAMT_W-1:0] r0_shamt,
    output logic               r0_rsp_valid,
    input  logic               r0_rsp_ready,
    input  logic               r1_req_valid,
    output logic               r1_req_ready,
    input  logic [OP_W-1:0]    r1_op,
    input  logic [DATA_W-1:0]  r1_a,
    input  logic [DATA_W-1:0]  r1_b,
    input  logic [SHAMT_W-1:0] r1_shamt,
    output logic               r1_rsp_valid,
    input  logic               r1_rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SHAMT_W-1:0] alu_shamt,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               owner_r;
    logic               grant_s;
    logic               grant_vld_s;
    logic               owner_ack_s;
    logic [OP_W-1:0]    op_r;
    logic [DATA_W-1:0]  a_r;
    logic [DATA_W-1:0]  b_r;
    logic [SHAMT_W-1:0] shamt_r;
    logic [DATA_W-1:0]  rsp_data_r;
    logic               rsp_zero_r;
    logic               rsp_err_r;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic               last_grant_r;
`endif

    // Codes above the eight defined ALU operations are flagged, never rewritten.
    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op > OP_W'(7));
    endfunction

    // Pick the winner among the currently valid requesters.
    always_comb begin
        grant_vld_s = r0_req_valid | r1_req_valid;
        if (r0_req_valid && r1_req_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_s = 1'b0;
`else
            grant_s = ~last_grant_r;
`endif
        end else if (r1_req_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Response acknowledge from the owning requester only.
    always_comb begin
        if (owner_r) begin
            owner_ack_s = r1_rsp_ready;
        end else begin
            owner_ack_s = r0_rsp_ready;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (owner_ack_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state and owner.
    always_comb begin
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s && !reset) begin
                    r0_req_ready = ~grant_s;
                    r1_req_ready = grant_s;
                end else begin
                    r0_req_ready = 1'b0;
                    r1_req_ready = 1'b0;
                end
            end
            ST_RESP: begin
                r0_rsp_valid = ~owner_r;
                r1_rsp_valid = owner_r;
            end
            default: begin
                r0_req_ready = 1'b0;
                r1_req_ready = 1'b0;
            end
        endcase
    end

    // Operand latch on grant and result capture in EXEC; values hold elsewhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            shamt_r    <= '0;
            owner_r    <= 1'b0;
            rsp_data_r <= '0;
            rsp_zero_r <= 1'b0;
            rsp_err_r  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_r <= 1'b1;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        op_r    <= grant_s ? r1_op    : r0_op;
                        a_r     <= grant_s ? r1_a     : r0_a;
                        b_r     <= grant_s ? r1_b     : r0_b;
                        shamt_r <= grant_s ? r1_shamt : r0_shamt;
                        owner_r <= grant_s;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant_r <= grant_s;
`endif
                    end
                end
                ST_EXEC: begin
                    rsp_data_r <= alu_result;
                    rsp_zero_r <= alu_zero;
                    rsp_err_r  <= is_illegal_op(op_r);
                end
                default: begin
                    rsp_data_r <= rsp_data_r;
                end
            endcase
        end
    end

    assign alu_op    = op_r;
    assign alu_a     = a_r;
    assign alu_b     = b_r;
    assign alu_shamt = shamt_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_zero  = rsp_zero_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model checked every cycle plus literal expectations.
module tb_alu_arbiter;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
    } req_t;

    typedef struct packed {
        logic        who;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_req_valid = 1'b0, r1_req_valid = 1'b0;
    logic        r0_req_ready, r1_req_ready;
    logic [3:0]  r0_op = '0, r1_op = '0;
    logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [4:0]  r0_shamt = '0, r1_shamt = '0;
    logic        r0_rsp_valid, r1_rsp_valid;
    logic        r0_rsp_ready = 1'b1, r1_rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_zero, rsp_err;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_shamt;
    logic        alu_zero;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    req_t q0[$];
    req_t q1[$];
    int   grant_log[$];
    rsp_t rsp_log[$];

    // transaction-level model state
    bit          m_busy = 1'b0;
    int          m_age = 0;
    int          m_owner = 0;
    int          m_last = 1;
    logic [31:0] m_data = '0;
    logic        m_zero = 1'b0, m_err = 1'b0;
    req_t        m_req = '0;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b), .r0_shamt(r0_shamt),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b), .r1_shamt(r1_shamt),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input req_t r);
        case (r.op)
            4'd0:    return r.a & r.b;
            4'd1:    return r.a | r.b;
            4'd2:    return ~(r.a | r.b);
            4'd3:    return r.a + r.b;
            4'd4:    return r.a - r.b;
            4'd5:    return r.b << r.shamt;
            4'd6:    return r.b >> r.shamt;
            4'd7:    return {r.b[15:0], 16'h0000};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Reference ALU attached to the arbiter
    always_comb alu_result = alu_ref('{op: alu_op, a: alu_a, b: alu_b, shamt: alu_shamt});
    assign alu_zero = (alu_result == 32'h0000_0000);

    function automatic int pick(input logic v0, input logic v1, input int last);
        if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 0;
`else
            return (last == 0) ? 1 : 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances one transaction step per clock edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_age <= 0; m_owner <= 0; m_last <= 1;
            m_data <= '0; m_zero <= 1'b0; m_err <= 1'b0; m_req <= '0;
        end else if (!m_busy) begin
            if (pick(r0_req_valid, r1_req_valid, m_last) >= 0) begin
                m_busy  <= 1'b1;
                m_age   <= 1;
                m_owner <= pick(r0_req_valid, r1_req_valid, m_last);
                m_last  <= pick(r0_req_valid, r1_req_valid, m_last);
                if (pick(r0_req_valid, r1_req_valid, m_last) == 1)
                    m_req <= '{op: r1_op, a: r1_a, b: r1_b, shamt: r1_shamt};
                else
                    m_req <= '{op: r0_op, a: r0_a, b: r0_b, shamt: r0_shamt};
            end
        end else if (m_age == 1) begin
            m_data <= alu_ref(m_req);
            m_zero <= (alu_ref(m_req) == 32'h0000_0000);
            m_err  <= (m_req.op > 4'd7);
            m_age  <= 2;
        end else if ((m_owner == 0) ? r0_rsp_ready : r1_rsp_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int w;
        if (cmp_en) begin
            w = (m_busy || reset) ? -1 : pick(r0_req_valid, r1_req_valid, m_last);
            check("cyc_r0_req_ready", 32'(r0_req_ready), 32'(w == 0));
            check("cyc_r1_req_ready", 32'(r1_req_ready), 32'(w == 1));
            check("cyc_r0_rsp_valid", 32'(r0_rsp_valid), 32'(m_busy && m_age == 2 && m_owner == 0));
            check("cyc_r1_rsp_valid", 32'(r1_rsp_valid), 32'(m_busy && m_age == 2 && m_owner == 1));
            check("cyc_rsp_data", rsp_data, m_data);
            check("cyc_rsp_zero", 32'(rsp_zero), 32'(m_zero));
            check("cyc_rsp_err", 32'(rsp_err), 32'(m_err));
            check("cyc_alu_op", 32'(alu_op), 32'(m_req.op));
            check("cyc_alu_a", alu_a, m_req.a);
            check("cyc_alu_b", alu_b, m_req.b);
            check("cyc_alu_shamt", 32'(alu_shamt), 32'(m_req.shamt));
        end
    end

    task automatic apply_reqs();
        if (q0.size() > 0) begin
            r0_req_valid = 1'b1;
            {r0_op, r0_a, r0_b, r0_shamt} = q0[0];
        end else begin
            r0_req_valid = 1'b0;
        end
        if (q1.size() > 0) begin
            r1_req_valid = 1'b1;
            {r1_op, r1_a, r1_b, r1_shamt} = q1[0];
        end else begin
            r1_req_valid = 1'b0;
        end
    endtask

    task automatic push(input int who, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
        if (who == 0) q0.push_back('{op: op, a: a, b: b, shamt: sh});
        else          q1.push_back('{op: op, a: a, b: b, shamt: sh});
    endtask

    // Requester driver: logs handshakes seen by the DUT and presents the next queued op
    initial begin
        bit hs0, hs1;
        forever begin
            @(negedge clk);
            hs0 = r0_req_valid && r0_req_ready && !reset;
            hs1 = r1_req_valid && r1_req_ready && !reset;
            if (hs0) grant_log.push_back(0);
            if (hs1) grant_log.push_back(1);
            if (!reset && r0_rsp_valid && r0_rsp_ready)
                rsp_log.push_back('{who: 1'b0, data: rsp_data, zero: rsp_zero, err: rsp_err});
            if (!reset && r1_rsp_valid && r1_rsp_ready)
                rsp_log.push_back('{who: 1'b1, data: rsp_data, zero: rsp_zero, err: rsp_err});
            @(posedge clk);
            #1;
            if (hs0 && q0.size() > 0) void'(q0.pop_front());
            if (hs1 && q1.size() > 0) void'(q1.pop_front());
            apply_reqs();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && !m_busy && !r0_req_valid && !r1_req_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check({"drain_", name}, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int gexp[4];
        #1 reset = 1'b1;
        tick();
        tick();
        cmp_en = 1'b1;
        check("rst_r0_req_ready", 32'(r0_req_ready), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        reset = 1'b0;
        tick();

        // 1: single ADD 5+3
        push(0, 4'd3, 32'd5, 32'd3, 5'd0);
        apply_reqs();
        #1;
        check("t1_r0_req_ready", 32'(r0_req_ready), 32'd1);
        check("t1_r1_req_ready", 32'(r1_req_ready), 32'd0);
        tick();
        check("t1_exec_ready", 32'(r0_req_ready), 32'd0);
        check("t1_exec_alu_op", 32'(alu_op), 32'd3);
        check("t1_exec_alu_a", alu_a, 32'd5);
        check("t1_exec_valid", 32'(r0_rsp_valid), 32'd0);
        tick();
        check("t1_rsp_valid", 32'(r0_rsp_valid), 32'd1);
        check("t1_rsp_data", rsp_data, 32'd8);
        check("t1_rsp_zero", 32'(rsp_zero), 32'd0);
        check("t1_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        check("t1_rsp_done", 32'(r0_rsp_valid), 32'd0);

        // 2: simultaneous requests right after reset, r0 wins
        do_reset();
        rsp_log.delete();
        grant_log.delete();
        push(0, 4'd4, 32'd7, 32'd7, 5'd0);
        push(1, 4'd1, 32'h0000_00F0, 32'h0000_000F, 5'd0);
        apply_reqs();
        wait_done("t2");
        check("t2_nrsp", 32'(rsp_log.size()), 32'd2);
        if (rsp_log.size() == 2) begin
            check("t2_first_who", 32'(rsp_log[0].who), 32'd0);
            check("t2_first_data", rsp_log[0].data, 32'd0);
            check("t2_first_zero", 32'(rsp_log[0].zero), 32'd1);
            check("t2_second_who", 32'(rsp_log[1].who), 32'd1);
            check("t2_second_data", rsp_log[1].data, 32'h0000_00FF);
        end

        // 3: both kept busy, grant order
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 4'd3, 32'(i), 32'd1, 5'd0);
            push(1, 4'd0, 32'(i), 32'hFFFF_FFFF, 5'd0);
        end
        apply_reqs();
        wait_done("t3");
`ifdef ALU_ARB_FIXED_PRIO_EN
        gexp = '{0, 0, 0, 0};
`else
        gexp = '{0, 1, 0, 1};
`endif
        check("t3_ngrants", 32'(grant_log.size()), 32'd8);
        if (grant_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) check("t3_grant", 32'(grant_log[i]), 32'(gexp[i]));
        end

        // 4: response back-pressure from r1
        r1_rsp_ready = 1'b0;
        rsp_log.delete();
        push(1, 4'd5, 32'd0, 32'd1, 5'd4);
        apply_reqs();
        tick();
        tick();
        push(0, 4'd0, 32'h0000_00FF, 32'h0000_000F, 5'd0);
        apply_reqs();
        #1;
        for (int i = 0; i < 5; i++) begin
            check("t4_r1_rsp_valid", 32'(r1_rsp_valid), 32'd1);
            check("t4_rsp_data", rsp_data, 32'd16);
            check("t4_r0_req_ready", 32'(r0_req_ready), 32'd0);
            tick();
        end
        r1_rsp_ready = 1'b1;
        wait_done("t4");
        check("t4_nrsp", 32'(rsp_log.size()), 32'd2);
        if (rsp_log.size() == 2) check("t4_r0_data", rsp_log[1].data, 32'h0000_000F);

        // 5: reset during EXEC discards the op
        push(0, 4'd3, 32'd1, 32'd2, 5'd0);
        apply_reqs();
        tick();
        check("t5_in_exec_alu_a", alu_a, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_alu_a", alu_a, 32'd0);
        check("t5_alu_b", alu_b, 32'd0);
        check("t5_rsp_data", rsp_data, 32'd0);
        check("t5_rsp_zero", 32'(rsp_zero), 32'd0);
        check("t5_r0_req_ready", 32'(r0_req_ready), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        n = rsp_log.size();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_no_rsp0", 32'(r0_rsp_valid), 32'd0);
            check("t5_no_rsp1", 32'(r1_rsp_valid), 32'd0);
        end
        check("t5_log", 32'(rsp_log.size()), 32'(n));

        // 6: illegal opcode and LUI
        rsp_log.delete();
        push(0, 4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        push(0, 4'd7, 32'd0, 32'h0000_1234, 5'd0);
        apply_reqs();
        wait_done("t6");
        check("t6_nrsp", 32'(rsp_log.size()), 32'd2);
        if (rsp_log.size() == 2) begin
            check("t6_ill_data", rsp_log[0].data, 32'd0);
            check("t6_ill_zero", 32'(rsp_log[0].zero), 32'd1);
            check("t6_ill_err", 32'(rsp_log[0].err), 32'd1);
            check("t6_lui_data", rsp_log[1].data, 32'h1234_0000);
            check("t6_lui_err", 32'(rsp_log[1].err), 32'd0);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
